// File: rtl/datamover_rd_sched.sv
// Splits one large MM2S read request into chunks of at most MAX_CHUNK bytes and pulses o_done when all are read.
// Optional WAIT-state watchdog enabled by defining DM_RD_TIMEOUT_EN (default build: no watchdog, o_timeout tied 0).
module datamover_rd_sched #(
    parameter int unsigned MAX_CHUNK   = 256,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_bytes,
    output logic        o_start,
    output logic [8:0]  o_length,
    output logic [31:0] o_start_addr,
    input  logic        i_mm2s_rd_tvalid,
    input  logic        i_mm2s_rd_tready,
    input  logic        i_mm2s_rd_tlast,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_chunk_cnt,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [31:0] MAX_CHUNK_W = 32'(MAX_CHUNK);

    function automatic logic [8:0] chunk_len(input logic [31:0] rem);
        return (rem > MAX_CHUNK_W) ? MAX_CHUNK_W[8:0] : rem[8:0];
    endfunction

    state_t      state_q, state_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] addr_q, addr_d;
    logic [8:0]  length_q, length_d;
    logic [31:0] start_addr_q, start_addr_d;
    logic [15:0] chunk_cnt_q, chunk_cnt_d;
    logic        busy_q, busy_d;
    logic        req_rdy_q, req_rdy_d;
    logic        timeout_q, timeout_d;
    logic        accept;
    logic        done_beat;

`ifdef DM_RD_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0] wcnt_q, wcnt_d;
`endif

    assign accept    = i_req_valid & req_rdy_q & (state_q == ST_IDLE);
    assign done_beat = i_mm2s_rd_tvalid & i_mm2s_rd_tready & i_mm2s_rd_tlast;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        addr_d       = addr_q;
        length_d     = length_q;
        start_addr_d = start_addr_q;
        chunk_cnt_d  = chunk_cnt_q;
        busy_d       = busy_q;
        timeout_d    = timeout_q;
`ifdef DM_RD_TIMEOUT_EN
        wcnt_d       = wcnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rem_d       = i_req_bytes;
                    addr_d      = i_req_addr;
                    chunk_cnt_d = 16'd0;
                    busy_d      = 1'b1;
                    timeout_d   = 1'b0;
                    state_d     = (i_req_bytes == 32'd0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                chunk_cnt_d = (chunk_cnt_q == 16'hFFFF) ? chunk_cnt_q : chunk_cnt_q + 16'd1;
`ifdef DM_RD_TIMEOUT_EN
                wcnt_d      = '0;
`endif
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_beat) begin
                    rem_d   = rem_q - {23'd0, length_q};
                    addr_d  = addr_q + {23'd0, length_q};
                    state_d = (rem_d == 32'd0) ? ST_DONE : ST_ISSUE;
`ifdef DM_RD_TIMEOUT_EN
                end else if (wcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
`endif
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Chunk descriptor is registered on entry to ISSUE and held through WAIT for late sampling downstream.
        if (state_d == ST_ISSUE) begin
            length_d     = chunk_len(rem_d);
            start_addr_d = addr_d;
        end

        req_rdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rem_q        <= 32'd0;
            addr_q       <= 32'd0;
            length_q     <= 9'd0;
            start_addr_q <= 32'd0;
            chunk_cnt_q  <= 16'd0;
            busy_q       <= 1'b0;
            req_rdy_q    <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef DM_RD_TIMEOUT_EN
            wcnt_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            addr_q       <= addr_d;
            length_q     <= length_d;
            start_addr_q <= start_addr_d;
            chunk_cnt_q  <= chunk_cnt_d;
            busy_q       <= busy_d;
            req_rdy_q    <= req_rdy_d;
            timeout_q    <= timeout_d;
`ifdef DM_RD_TIMEOUT_EN
            wcnt_q       <= wcnt_d;
`endif
        end
    end

    assign o_req_ready  = req_rdy_q;
    assign o_start      = (state_q == ST_ISSUE);
    assign o_done       = (state_q == ST_DONE);
    assign o_length     = length_q;
    assign o_start_addr = start_addr_q;
    assign o_busy       = busy_q;
    assign o_chunk_cnt  = chunk_cnt_q;
    assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_datamover_rd_sched.sv
// Directed bench for datamover_rd_sched: chunking, zero-length, stalls, reset mid-request, watchdog.
module tb_datamover_rd_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_bytes;
    logic        o_start;
    logic [8:0]  o_length;
    logic [31:0] o_start_addr;
    logic        i_mm2s_rd_tvalid;
    logic        i_mm2s_rd_tready;
    logic        i_mm2s_rd_tlast;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_chunk_cnt;
    logic        o_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int start_seen = 0;
    int done_seen  = 0;

    always #5 clk = ~clk;

    datamover_rd_sched #(.MAX_CHUNK(256), .TIMEOUT_CYC(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_req_valid      (i_req_valid),
        .o_req_ready      (o_req_ready),
        .i_req_addr       (i_req_addr),
        .i_req_bytes      (i_req_bytes),
        .o_start          (o_start),
        .o_length         (o_length),
        .o_start_addr     (o_start_addr),
        .i_mm2s_rd_tvalid (i_mm2s_rd_tvalid),
        .i_mm2s_rd_tready (i_mm2s_rd_tready),
        .i_mm2s_rd_tlast  (i_mm2s_rd_tlast),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_chunk_cnt      (o_chunk_cnt),
        .o_timeout        (o_timeout)
    );

    always @(negedge clk) begin
        if (o_start === 1'b1) start_seen++;
        if (o_done === 1'b1)  done_seen++;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_beat(input logic v, input logic r, input logic l);
        i_mm2s_rd_tvalid = v;
        i_mm2s_rd_tready = r;
        i_mm2s_rd_tlast  = l;
    endtask

    task automatic request(input logic [31:0] addr, input logic [31:0] bytes);
        i_req_valid = 1'b1;
        i_req_addr  = addr;
        i_req_bytes = bytes;
        step();
        i_req_valid = 1'b0;
        i_req_addr  = 32'hDEAD_BEEF;
        i_req_bytes = 32'h0000_0044;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_req_valid = 1'b1;
        i_req_addr  = 32'h1234_5678;
        i_req_bytes = 32'd64;
        set_beat(1'b1, 1'b1, 1'b1);
        step();
        step();
        n_tests++;
        if ({o_start, o_done, o_busy, o_timeout, o_req_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b exp 00000", {o_start, o_done, o_busy, o_timeout, o_req_ready});
        end
        n_tests++;
        if ({o_length, o_start_addr, o_chunk_cnt} !== 57'd0) begin
            n_fail++;
            $display("FAIL reset_data: len %0d addr %h cnt %0d exp all 0", o_length, o_start_addr, o_chunk_cnt);
        end
        i_req_valid = 1'b0;
        set_beat(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        n_tests++;
        if (o_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after: got %b exp 1", o_req_ready);
        end
    endtask

    task automatic test_multi_chunk();
        logic [31:0] exp_addr [4];
        logic [8:0]  exp_len  [4];
        int s0, d0;
        exp_addr = '{32'h1000_0000, 32'h1000_0100, 32'h1000_0200, 32'h1000_0300};
        exp_len  = '{9'd256, 9'd256, 9'd256, 9'd232};
        s0 = start_seen;
        d0 = done_seen;
        request(32'h1000_0000, 32'd1000);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (o_start !== 1'b1 || o_length !== exp_len[k] || o_start_addr !== exp_addr[k] || o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL multi_issue%0d: start %b len %0d addr %h busy %b exp 1 %0d %h 1",
                         k, o_start, o_length, o_start_addr, o_busy, exp_len[k], exp_addr[k]);
            end
            step();
            set_beat(1'b1, 1'b1, 1'b0);
            n_tests++;
            if (o_start !== 1'b0 || o_chunk_cnt !== 16'(k + 1) || o_length !== exp_len[k]) begin
                n_fail++;
                $display("FAIL multi_wait%0d: start %b cnt %0d len %0d exp 0 %0d %0d",
                         k, o_start, o_chunk_cnt, o_length, k + 1, exp_len[k]);
            end
            step();
            i_mm2s_rd_tlast = 1'b1;
            n_tests++;
            if (o_start !== 1'b0 || o_done !== 1'b0 || o_start_addr !== exp_addr[k]) begin
                n_fail++;
                $display("FAIL multi_nonlast%0d: start %b done %b addr %h exp 0 0 %h",
                         k, o_start, o_done, o_start_addr, exp_addr[k]);
            end
            step();
            set_beat(1'b0, 1'b0, 1'b0);
        end
        n_tests++;
        if (o_done !== 1'b1 || o_busy !== 1'b1 || o_chunk_cnt !== 16'd4 || o_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_done: done %b busy %b cnt %0d ready %b exp 1 1 4 0",
                     o_done, o_busy, o_chunk_cnt, o_req_ready);
        end
        step();
        n_tests++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_req_ready !== 1'b1 ||
            start_seen - s0 != 4 || done_seen - d0 != 1) begin
            n_fail++;
            $display("FAIL multi_after: done %b busy %b ready %b starts %0d dones %0d exp 0 0 1 4 1",
                     o_done, o_busy, o_req_ready, start_seen - s0, done_seen - d0);
        end
    endtask

    task automatic test_exact_multiple();
        int s0, d0;
        s0 = start_seen;
        d0 = done_seen;
        request(32'h0000_4000, 32'd512);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (o_start !== 1'b1 || o_length !== 9'd256 || o_start_addr !== 32'h0000_4000 + 32'(k * 256)) begin
                n_fail++;
                $display("FAIL exact_issue%0d: start %b len %0d addr %h exp 1 256 %h",
                         k, o_start, o_length, o_start_addr, 32'h0000_4000 + 32'(k * 256));
            end
            step();
            set_beat(1'b1, 1'b1, 1'b1);
            step();
            set_beat(1'b0, 1'b0, 1'b0);
        end
        n_tests++;
        if (o_done !== 1'b1 || o_start !== 1'b0 || o_chunk_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL exact_done: done %b start %b cnt %0d exp 1 0 2", o_done, o_start, o_chunk_cnt);
        end
        step();
        step();
        n_tests++;
        if (start_seen - s0 != 2 || done_seen - d0 != 1 || o_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL exact_count: starts %0d dones %0d ready %b exp 2 1 1",
                     start_seen - s0, done_seen - d0, o_req_ready);
        end
    endtask

    task automatic test_zero_bytes();
        int s0;
        s0 = start_seen;
        request(32'h0000_8000, 32'd0);
        n_tests++;
        if (o_start !== 1'b0 || o_done !== 1'b1 || o_busy !== 1'b1 || o_chunk_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL zero_done: start %b done %b busy %b cnt %0d exp 0 1 1 0",
                     o_start, o_done, o_busy, o_chunk_cnt);
        end
        step();
        n_tests++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_req_ready !== 1'b1 || start_seen != s0) begin
            n_fail++;
            $display("FAIL zero_after: done %b busy %b ready %b starts %0d exp 0 0 1 0",
                     o_done, o_busy, o_req_ready, start_seen - s0);
        end
    endtask

    task automatic test_tready_stall();
        request(32'hFFFF_FF80, 32'd300);
        step();
        set_beat(1'b1, 1'b0, 1'b1);
        step();
        step();
        n_tests++;
        if (o_start !== 1'b0 || o_busy !== 1'b1 || o_start_addr !== 32'hFFFF_FF80) begin
            n_fail++;
            $display("FAIL stall_hold: start %b busy %b addr %h exp 0 1 ffffff80", o_start, o_busy, o_start_addr);
        end
        i_mm2s_rd_tready = 1'b1;
        step();
        set_beat(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (o_start !== 1'b1 || o_start_addr !== 32'h0000_0080 || o_length !== 9'd44) begin
            n_fail++;
            $display("FAIL stall_wrap: start %b addr %h len %0d exp 1 00000080 44", o_start, o_start_addr, o_length);
        end
        step();
        set_beat(1'b1, 1'b1, 1'b1);
        step();
        set_beat(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (o_done !== 1'b1 || o_chunk_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL stall_done: done %b cnt %0d exp 1 2", o_done, o_chunk_cnt);
        end
        step();
    endtask

    task automatic test_reset_midop();
        int s0, d0;
        request(32'h2000_0000, 32'd1000);
        step();
        set_beat(1'b1, 1'b1, 1'b1);
        step();
        set_beat(1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        n_tests++;
        if ({o_start, o_done, o_busy, o_req_ready} !== 4'b0 || o_chunk_cnt !== 16'd0 ||
            o_length !== 9'd0 || o_start_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_state: flags %b cnt %0d len %0d addr %h exp 0000 0 0 0",
                     {o_start, o_done, o_busy, o_req_ready}, o_chunk_cnt, o_length, o_start_addr);
        end
        rst_n = 1'b1;
        step();
        s0 = start_seen;
        d0 = done_seen;
        set_beat(1'b1, 1'b1, 1'b1);
        step();
        step();
        set_beat(1'b0, 1'b0, 1'b0);
        step();
        n_tests++;
        if (start_seen != s0 || done_seen != d0 || o_busy !== 1'b0 || o_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_idle: starts %0d dones %0d busy %b ready %b exp 0 0 0 1",
                     start_seen - s0, done_seen - d0, o_busy, o_req_ready);
        end
        request(32'h0000_0040, 32'd8);
        n_tests++;
        if (o_start !== 1'b1 || o_length !== 9'd8 || o_start_addr !== 32'h0000_0040) begin
            n_fail++;
            $display("FAIL midrst_new: start %b len %0d addr %h exp 1 8 00000040", o_start, o_length, o_start_addr);
        end
        step();
        set_beat(1'b1, 1'b1, 1'b1);
        step();
        set_beat(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (o_done !== 1'b1 || o_chunk_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL midrst_done: done %b cnt %0d exp 1 1", o_done, o_chunk_cnt);
        end
        step();
    endtask

    task automatic test_watchdog();
        int d0;
        d0 = done_seen;
        request(32'h0000_9000, 32'd64);
`ifdef DM_RD_TIMEOUT_EN
        for (int i = 0; i < 16; i++) step();
        n_tests++;
        if (o_done !== 1'b0 || o_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL wdog_early: done %b timeout %b exp 0 0", o_done, o_timeout);
        end
        step();
        n_tests++;
        if (o_done !== 1'b1 || o_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL wdog_fire: done %b timeout %b exp 1 1", o_done, o_timeout);
        end
        step();
        n_tests++;
        if (o_timeout !== 1'b1 || o_req_ready !== 1'b1 || done_seen - d0 != 1) begin
            n_fail++;
            $display("FAIL wdog_sticky: timeout %b ready %b dones %0d exp 1 1 1", o_timeout, o_req_ready, done_seen - d0);
        end
        request(32'h0, 32'd0);
        n_tests++;
        if (o_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL wdog_clear: timeout %b exp 0", o_timeout);
        end
        step();
`else
        for (int i = 0; i < 40; i++) step();
        n_tests++;
        if (o_busy !== 1'b1 || o_timeout !== 1'b0 || done_seen != d0) begin
            n_fail++;
            $display("FAIL nowdog_wait: busy %b timeout %b dones %0d exp 1 0 0", o_busy, o_timeout, done_seen - d0);
        end
        set_beat(1'b1, 1'b1, 1'b1);
        step();
        set_beat(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (o_done !== 1'b1 || o_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL nowdog_done: done %b timeout %b exp 1 0", o_done, o_timeout);
        end
        step();
`endif
    endtask

    initial begin
        rst_n       = 1'b0;
        i_req_valid = 1'b0;
        i_req_addr  = 32'd0;
        i_req_bytes = 32'd0;
        set_beat(1'b0, 1'b0, 1'b0);
        step();
        test_reset();
        test_multi_chunk();
        test_exact_multiple();
        test_zero_bytes();
        test_tready_stall();
        test_reset_midop();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
